// File: rtl/cic_comb_sched_if.sv
// Sample-in / result-out bundle of the CIC comb scheduler: integrator samples,
// synchronous flush, comb results and status flags.
interface cic_comb_sched_if #(
  parameter int WIDTH = 32
);
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             overrun;

  modport master (
    output clr, in_valid, in_data,
    input  out_valid, out_data, busy, overrun
  );

  modport slave (
    input  clr, in_valid, in_data,
    output out_valid, out_data, busy, overrun
  );
endinterface

// File: rtl/cic_comb_sched.sv
// Decimating CIC comb section: one shared subtractor walks all comb stages,
// one stage per clock, after every DECIM-th integrator sample.
module cic_comb_sched #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int DECIM  = 64
) (
  input  logic            clk,
  input  logic            rst,
  cic_comb_sched_if.slave bus
);
  localparam int DEC_W = $clog2(DECIM);
  localparam int STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  // Delay memory is padded to a power of two so stg_q indexes it exactly.
  localparam int DLY_N = 1 << STG_W;

  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);
  localparam logic [DEC_W-1:0] DEC_ZERO = {DEC_W{1'b0}};
  localparam logic [DEC_W-1:0] DEC_ONE  = {{(DEC_W-1){1'b0}}, 1'b1};
  localparam logic [STG_W-1:0] STG_ZERO = {STG_W{1'b0}};
  localparam logic [STG_W-1:0] STG_ONE  = {{(STG_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dly_q [DLY_N];
  logic [WIDTH-1:0] dly_d [DLY_N];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             capture_s;
  logic [WIDTH-1:0] diff_s;

  assign capture_s = bus.in_valid && (dec_cnt_q == DEC_LAST);
  assign diff_s    = acc_q - dly_q[stg_q];

  // Next-state logic: decimation counter, stage sequencer and shared subtractor.
  always_comb begin
    state_d     = state_q;
    dec_cnt_d   = dec_cnt_q;
    stg_d       = stg_q;
    acc_d       = acc_q;
    dly_d       = dly_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    if (bus.clr) begin
      state_d    = IDLE;
      dec_cnt_d  = DEC_ZERO;
      stg_d      = STG_ZERO;
      acc_d      = DAT_ZERO;
      out_data_d = DAT_ZERO;
      overrun_d  = 1'b0;
      for (int i = 0; i < DLY_N; i++) begin
        dly_d[i] = DAT_ZERO;
      end
    end else begin
      if (bus.in_valid) begin
        dec_cnt_d = capture_s ? DEC_ZERO : (dec_cnt_q + DEC_ONE);
      end else begin
        dec_cnt_d = dec_cnt_q;
      end

      case (state_q)
        IDLE: begin
          if (capture_s) begin
            acc_d   = bus.in_data;
            stg_d   = STG_ZERO;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          acc_d        = diff_s;
          dly_d[stg_q] = acc_q;
          if (stg_q == STG_LAST) begin
            out_data_d  = diff_s;
            out_valid_d = 1'b1;
            stg_d       = STG_ZERO;
            // A capture on the final stage starts the next sample without a gap.
            if (capture_s) begin
              acc_d   = bus.in_data;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stg_d = stg_q + STG_ONE;
            if (capture_s) begin
              overrun_d = 1'b1;
            end else begin
              overrun_d = overrun_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          stg_d   = STG_ZERO;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dec_cnt_q   <= DEC_ZERO;
      stg_q       <= STG_ZERO;
      acc_q       <= DAT_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= DAT_ZERO;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < DLY_N; i++) begin
        dly_q[i] <= DAT_ZERO;
      end
    end else begin
      state_q     <= state_d;
      dec_cnt_q   <= dec_cnt_d;
      stg_q       <= stg_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      dly_q       <= dly_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_cic_comb_sched.sv
// Scoreboard bench for cic_comb_sched: three parameterisations driven with
// directed vectors, results checked for value and arrival cycle.
module tb_cic_comb_sched;
  localparam int W   = 32;
  localparam int S_A = 2;
  localparam int S_B = 1;
  localparam int S_C = 4;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  logic [W-1:0] exp1 [4] = '{32'd5, 32'hFFFF_FFFB, 32'd0, 32'd0};
  logic [W-1:0] exp2 [4] = '{32'd1, 32'd2, 32'd2, 32'd2};
  logic [W-1:0] exp3 [4] = '{32'd7, 32'hFFFF_FFEB, 32'd21, 32'hFFFF_FFF9};

  cic_comb_sched_if #(.WIDTH(W)) if_a ();
  cic_comb_sched_if #(.WIDTH(W)) if_b ();
  cic_comb_sched_if #(.WIDTH(W)) if_c ();

  cic_comb_sched #(.WIDTH(W), .STAGES(S_A), .DECIM(4)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  cic_comb_sched #(.WIDTH(W), .STAGES(S_B), .DECIM(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  cic_comb_sched #(.WIDTH(W), .STAGES(S_C), .DECIM(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [W-1:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got out_valid=1 data=0x%08h, expected no pulse", name, act);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_a.out_valid === 1'b1) begin
        if (q_a.size() == 0) unexpected("a_unexpected_valid", if_a.out_data);
        else begin
          e = q_a.pop_front();
          check("a_out_data", if_a.out_data, e.data);
          check("a_out_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (if_b.out_valid === 1'b1) begin
        if (q_b.size() == 0) unexpected("b_unexpected_valid", if_b.out_data);
        else begin
          e = q_b.pop_front();
          check("b_out_data", if_b.out_data, e.data);
          check("b_out_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (if_c.out_valid === 1'b1) begin
        if (q_c.size() == 0) unexpected("c_unexpected_valid", if_c.out_data);
        else begin
          e = q_c.pop_front();
          check("c_out_data", if_c.out_data, e.data);
          check("c_out_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic idle_all();
    if_a.in_valid = 1'b0; if_a.in_data = 32'd0; if_a.clr = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = 32'd0; if_b.clr = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = 32'd0; if_c.clr = 1'b0;
  endtask

  // One cycle of stimulus on instance 'which' (others idle); a pushed
  // expectation arrives STAGES clocks after the sampling edge.
  task automatic drv(input int which, input logic v, input logic [W-1:0] d, input logic c,
                     input logic push, input logic [W-1:0] e);
    @(negedge clk);
    idle_all();
    case (which)
      0: begin
        if_a.in_valid = v; if_a.in_data = d; if_a.clr = c;
        if (push) q_a.push_back('{data: e, cyc: cyc + 1 + S_A});
      end
      1: begin
        if_b.in_valid = v; if_b.in_data = d; if_b.clr = c;
        if (push) q_b.push_back('{data: e, cyc: cyc + 1 + S_B});
      end
      2: begin
        if_c.in_valid = v; if_c.in_data = d; if_c.clr = c;
        if (push) q_c.push_back('{data: e, cyc: cyc + 1 + S_C});
      end
      default: begin
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(-1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_a_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_a_out_data", if_a.out_data, 32'd0);
    check("rst_a_busy", 32'(if_a.busy), 32'd0);
    check("rst_a_overrun", 32'(if_a.overrun), 32'd0);
    check("rst_c_out_data", if_c.out_data, 32'd0);
    rst = 1'b1;
    idle(2);

    // STAGES=2, DECIM=4, constant 5
    for (int i = 0; i < 16; i++) drv(0, 1'b1, 32'd5, 1'b0, (i % 4 == 3), exp1[i / 4]);
    idle(6);
    check("a_overrun_none", 32'(if_a.overrun), 32'd0);

    // STAGES=1, DECIM=2, ramp
    for (int i = 0; i < 8; i++) drv(1, 1'b1, 32'(i), 1'b0, (i % 2 == 1), exp2[i / 2]);
    idle(4);

    // STAGES=4, DECIM=2: every other capture dropped
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drv(2, 1'b1, 32'd7, 1'b0, (i % 4 == 1), exp3[i / 4]);
      if (if_c.busy === 1'b1) busy_cnt++;
      if (i == 3) check("c_overrun_before_drop", 32'(if_c.overrun), 32'd0);
      if (i == 4) check("c_overrun_after_drop", 32'(if_c.overrun), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      drv(-1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      if (if_c.busy === 1'b1) busy_cnt++;
    end
    check("c_busy_cycles", 32'(busy_cnt), 32'd16);
    check("c_overrun_sticky", 32'(if_c.overrun), 32'd1);

    // Asynchronous reset at stg=1 aborts the computation
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    idle(2);
    check("c_busy_midrun", 32'(if_c.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_c_out_valid", 32'(if_c.out_valid), 32'd0);
    check("arst_c_out_data", if_c.out_data, 32'd0);
    check("arst_c_busy", 32'(if_c.busy), 32'd0);
    check("arst_c_overrun", 32'(if_c.overrun), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(6);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b1, 32'd7);
    idle(8);

    // clr flushes delay memory, then clr coincident with a capture
    drv(2, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b1, 32'd7);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    idle(6);
    check("c_overrun_before_clr", 32'(if_c.overrun), 32'd1);
    drv(2, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd123, 1'b1, 1'b0, 32'd0);
    idle(1);
    check("clr_c_overrun", 32'(if_c.overrun), 32'd0);
    check("clr_c_out_data", if_c.out_data, 32'd0);
    check("clr_c_busy", 32'(if_c.busy), 32'd0);
    drv(2, 1'b1, 32'd9, 1'b0, 1'b0, 32'd0);
    drv(2, 1'b1, 32'd11, 1'b0, 1'b1, 32'd11);
    idle(8);

    // DECIM=4 with gapped in_valid: capture on the 4th valid only
    for (int j = 1; j <= 7; j++) begin
      if (j % 2 == 1) drv(0, 1'b1, 32'(10 * ((j + 1) / 2)), 1'b0, (j == 7), 32'd40);
      else drv(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
      if (j == 5) check("a_gap_busy_idle", 32'(if_a.busy), 32'd0);
    end
    idle(10);

    check("a_pending", 32'(q_a.size()), 32'd0);
    check("b_pending", 32'(q_b.size()), 32'd0);
    check("c_pending", 32'(q_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
